// File: rtl/tc_result_drain.sv
// Tensor-core result collector: accumulates K-step partial-sum tiles, then drains rows over valid/ready.
// Optional TC_DRAIN_SAT_EN: saturating element adds with a sticky per-tile overflow flag.

module tc_drain_elem #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] elem,
  input  logic          first,
`ifdef TC_DRAIN_SAT_EN
  output logic          sat,
`endif
  output logic [DW-1:0] nxt
);
  logic [DW-1:0] sum;

  always_comb begin
    sum = acc + elem;
    nxt = sum;
`ifdef TC_DRAIN_SAT_EN
    sat = 1'b0;
`endif
    if (first) begin
      nxt = elem;
    end
`ifdef TC_DRAIN_SAT_EN
    // Like-signed operands producing an opposite-signed sum means the add overflowed.
    else if ((acc[DW-1] == elem[DW-1]) && (sum[DW-1] != acc[DW-1])) begin
      sat = 1'b1;
      nxt = acc[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
`endif
  end
endmodule

module tc_result_drain #(
  parameter int TILE_M = 4,
  parameter int TILE_N = 4,
  parameter int DW_OUT = 32,
  parameter int ROW_W  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic [TILE_M*TILE_N*DW_OUT-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TILE_N*DW_OUT-1:0]        out_data,
  output logic [ROW_W-1:0]                out_row,
  output logic                            out_last,
  output logic                            out_ovf
);
  typedef enum logic {ACC, DRAIN} state_t;

  state_t                                     state_q, state_d;
  logic                                       first_q, first_d;
  logic [ROW_W-1:0]                           row_q, row_d;
  logic [TILE_M-1:0][TILE_N-1:0][DW_OUT-1:0]  acc_q, acc_d, nxt_w;
  logic                                       accept;
  logic                                       last_row;
`ifdef TC_DRAIN_SAT_EN
  logic                                       ovf_q, ovf_d;
  logic [TILE_M-1:0][TILE_N-1:0]              sat_w;
`endif

  for (genvar m = 0; m < TILE_M; m++) begin : g_m
    for (genvar n = 0; n < TILE_N; n++) begin : g_n
      tc_drain_elem #(.DW(DW_OUT)) u_elem (
        .acc   (acc_q[m][n]),
        .elem  (in_data[(m*TILE_N+n)*DW_OUT +: DW_OUT]),
        .first (first_q),
`ifdef TC_DRAIN_SAT_EN
        .sat   (sat_w[m][n]),
`endif
        .nxt   (nxt_w[m][n])
      );
    end
  end

  assign accept   = (state_q == ACC) && in_valid;
  assign last_row = (row_q == ROW_W'(TILE_M-1));

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    row_d   = row_q;
    acc_d   = acc_q;
`ifdef TC_DRAIN_SAT_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      acc_d   = nxt_w;
      first_d = 1'b0;
`ifdef TC_DRAIN_SAT_EN
      ovf_d   = (first_q ? 1'b0 : ovf_q) | (|sat_w);
`endif
      if (in_last) begin
        state_d = DRAIN;
        row_d   = '0;
      end
    end else if ((state_q == DRAIN) && out_ready) begin
      if (last_row) begin
        state_d = ACC;
        first_d = 1'b1;
        row_d   = '0;
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      first_q <= 1'b1;
      row_q   <= '0;
      acc_q   <= '0;
`ifdef TC_DRAIN_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
`ifdef TC_DRAIN_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DRAIN);
  assign out_data  = acc_q[row_q];
  assign out_row   = row_q;
  assign out_last  = (state_q == DRAIN) && last_row;
`ifdef TC_DRAIN_SAT_EN
  assign out_ovf   = ovf_q;
`else
  assign out_ovf   = 1'b0;
`endif
endmodule
